// File: rtl/gmii_tx_pkg.sv
// Shared state encoding and fixed symbol values for the GMII transmit framer.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    ERR,
    DISCARD,
    IPG
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] UNDERRUN_BYTE = 8'h00;

endpackage

// File: rtl/gmii_tx_framer.sv
// Frames a MAC byte stream for the 1000BASE-T PCS encoder: preamble/SFD insertion,
// underrun signalling, minimum inter-packet gap and symbol time indexing.
//
// state   | meaning
// IDLE    | waiting for a frame, output idle
// PRE     | emitting preamble bytes
// SFD     | emitting start-of-frame delimiter, first beat accepted here
// DATA    | forwarding accepted beats one cycle later
// ERR     | single error symbol after an underrun
// DISCARD | dropping beats of a broken frame up to its last
// IPG     | holding enable low for the gap
module gmii_tx_framer
  import gmii_tx_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IPG_BYTES      = 12,
  parameter int N_WIDTH        = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [7:0]         io_in_data,
  input  logic               io_in_last,
  input  logic               io_in_error,
  output logic               io_tx_enable,
  output logic [7:0]         io_tx_data,
  output logic               io_tx_error,
  output logic [N_WIDTH-1:0] io_n,
  output logic [N_WIDTH-1:0] io_n0
);

  localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0] IPG_LOAD = 8'(IPG_BYTES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tx_en_d, tx_err_d, sof;
  logic [7:0] tx_data_d;

  assign io_in_ready = (state_q == SFD) || (state_q == DATA) || (state_q == DISCARD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_en_d   = 1'b0;
    tx_data_d = 8'h00;
    tx_err_d  = 1'b0;
    sof       = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          state_d   = PRE;
          cnt_d     = PRE_LOAD;
          tx_en_d   = 1'b1;
          tx_data_d = PREAMBLE_BYTE;
          sof       = 1'b1;
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d   = SFD;
          tx_data_d = SFD_BYTE;
        end else begin
          tx_data_d = PREAMBLE_BYTE;
          cnt_d     = cnt_q - 8'd1;
        end
      end
      SFD, DATA: begin
        tx_en_d = 1'b1;
        if (io_in_valid) begin
          tx_data_d = io_in_data;
          tx_err_d  = io_in_error;
          if (io_in_last) begin
            state_d = IPG;
            cnt_d   = IPG_LOAD;
          end else begin
            state_d = DATA;
          end
        end else begin
          // Upstream starved mid-frame: poison the frame on the line.
          tx_data_d = UNDERRUN_BYTE;
          tx_err_d  = 1'b1;
          state_d   = ERR;
        end
      end
      ERR: state_d = DISCARD;
      DISCARD: begin
        if (io_in_valid && io_in_last) begin
          state_d = IPG;
          cnt_d   = IPG_LOAD;
        end
      end
      IPG: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      io_tx_enable <= 1'b0;
      io_tx_data   <= 8'h00;
      io_tx_error  <= 1'b0;
      io_n         <= '0;
      io_n0        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      io_tx_enable <= tx_en_d;
      io_tx_data   <= tx_data_d;
      io_tx_error  <= tx_err_d;
      io_n         <= io_n + N_WIDTH'(1);
      // Record the index that will be on io_n when the first preamble byte shows.
      if (sof) io_n0 <= io_n + N_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: driver pushes expected line bytes, a monitor pops them.
module tb_gmii_tx_framer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0, io_in_last = 1'b0, io_in_error = 1'b0;
  logic [7:0]  io_in_data = 8'h00;
  logic        io_in_ready, io_tx_enable, io_tx_error;
  logic [7:0]  io_tx_data;
  logic [31:0] io_n, io_n0;

  logic        reset2 = 1'b0;
  logic        valid2 = 1'b0;
  logic        ready2, en2, err2;
  logic [7:0]  data2;
  logic [3:0]  n2, n0_2;

  gmii_tx_framer #(.PREAMBLE_BYTES(7), .IPG_BYTES(12), .N_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_data(io_in_data),
    .io_in_last(io_in_last), .io_in_error(io_in_error),
    .io_tx_enable(io_tx_enable), .io_tx_data(io_tx_data), .io_tx_error(io_tx_error),
    .io_n(io_n), .io_n0(io_n0)
  );

  gmii_tx_framer #(.PREAMBLE_BYTES(7), .IPG_BYTES(12), .N_WIDTH(4)) dut_wrap (
    .clock(clock), .reset(reset2),
    .io_in_valid(valid2), .io_in_ready(ready2), .io_in_data(8'h00),
    .io_in_last(1'b0), .io_in_error(1'b0),
    .io_tx_enable(en2), .io_tx_data(data2), .io_tx_error(err2),
    .io_n(n2), .io_n0(n0_2)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  logic [8:0]  exp_q[$];
  int          gap_q[$];
  logic [31:0] n_model;
  logic        cnt_en = 1'b0;
  int          ready_cnt = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) n_model <= 32'd0;
    else       n_model <= n_model + 32'd1;
  end

  // Monitor: line bytes against the scoreboard, gaps and start indices at each frame start.
  logic       mon_prev_en = 1'b0;
  int         mon_gap = 0;
  int         mon_g;
  logic [8:0] mon_e;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_prev_en = 1'b0;
        mon_gap     = 0;
      end else begin
        if (cnt_en && io_in_ready) ready_cnt++;
        if (io_tx_enable) begin
          if (!mon_prev_en) begin
            if (gap_q.size() > 0) begin
              mon_g = gap_q.pop_front();
              if (mon_g >= 0) check("ipg_gap", mon_gap, mon_g);
            end
            check("n_at_sof", io_n, n_model);
            check("n0_at_sof", io_n0, n_model);
            mon_gap = 0;
          end
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_output: actual %0h, required none", {io_tx_error, io_tx_data});
          end else begin
            mon_e = exp_q.pop_front();
            check("tx_byte", {io_tx_error, io_tx_data}, mon_e);
          end
        end else begin
          mon_gap++;
        end
        mon_prev_en = io_tx_enable;
      end
    end
  end

  logic [7:0] fr_data[8];
  logic       fr_err[8];

  // Presents one frame; drop_at > 0 withholds valid for one cycle before beat drop_at.
  task automatic run_frame(input int len, input int drop_at, input int gap, input logic set_last);
    logic discard;
    logic accepted;
    int   tries;
    gap_q.push_back(gap);
    for (int p = 0; p < 7; p++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    discard = 1'b0;
    for (int i = 0; i < len; i++) begin
      accepted = 1'b0;
      tries    = 0;
      while (!accepted) begin
        @(negedge clock);
        io_in_valid = 1'b1;
        io_in_data  = fr_data[i];
        io_in_error = fr_err[i];
        io_in_last  = set_last && (i == len - 1);
        if (io_in_ready) begin
          accepted = 1'b1;
          if (!discard) exp_q.push_back({fr_err[i], fr_data[i]});
        end else begin
          tries++;
          if (tries > 100) begin
            checks++;
            fails++;
            $display("FAIL beat_accept_timeout: actual none, required beat %0d accepted", i);
            return;
          end
        end
      end
      if (i + 1 == drop_at) begin
        @(negedge clock);
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        io_in_error = 1'b0;
        exp_q.push_back({1'b1, 8'h00});
        discard = 1'b1;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    reset2 = 1'b1;
    #2;
    check("rst_enable", io_tx_enable, 0);
    check("rst_data", io_tx_data, 0);
    check("rst_error", io_tx_error, 0);
    check("rst_n", io_n, 0);
    check("rst_n0", io_n0, 0);
    check("rst_ready", io_in_ready, 0);
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    cnt_en = 1'b1;
    repeat (9) @(negedge clock);

    fr_data[0] = 8'hA1; fr_data[1] = 8'hB2; fr_data[2] = 8'hC3; fr_data[3] = 8'hD4;
    for (int i = 0; i < 8; i++) fr_err[i] = 1'b0;
    run_frame(4, 0, -1, 1'b1);
    @(posedge clock);
    #1 cnt_en = 1'b0;
    check("ready_cycles_a", ready_cnt, 4);

    fr_data[0] = 8'h10; fr_data[1] = 8'h20; fr_data[2] = 8'h30; fr_data[3] = 8'h40;
    fr_err[2] = 1'b1;
    run_frame(4, 0, 12, 1'b1);
    fr_err[2] = 1'b0;

    for (int i = 0; i < 6; i++) fr_data[i] = 8'(i + 1);
    run_frame(6, 2, 12, 1'b1);

    // 4 discarded beats + error cycle's following slot + IPG
    fr_data[0] = 8'h77;
    run_frame(1, 0, 17, 1'b1);

    fr_data[0] = 8'h11; fr_data[1] = 8'h22; fr_data[2] = 8'h33; fr_data[3] = 8'h44;
    run_frame(4, 0, 12, 1'b0);
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_enable", io_tx_enable, 0);
    check("async_rst_n", io_n, 0);
    check("async_rst_n0", io_n0, 0);
    check("async_rst_ready", io_in_ready, 0);
    check("pending_after_rst", exp_q.size(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("idle_ready", io_in_ready, 0);
      check("idle_enable", io_tx_enable, 0);
    end

    @(negedge clock);
    reset2 = 1'b0;
    repeat (14) @(negedge clock);
    check("wrap_n_14", n2, 14);
    valid2 = 1'b1;
    @(negedge clock);
    valid2 = 1'b0;
    check("wrap_n_15", n2, 15);
    check("wrap_sof_enable", en2, 1);
    check("wrap_sof_data", data2, 8'h55);
    check("wrap_n0", n0_2, 15);
    @(negedge clock);
    check("wrap_n_0", n2, 0);
    @(negedge clock);
    check("wrap_n_1", n2, 1);
    check("wrap_n0_held", n0_2, 15);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    check("gap_queue_empty", gap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
